// File: rtl/nn_score_pkg.sv
// rtl/nn_score_pkg.sv - shared types and one-hot helpers for inference scoring
package nn_score_pkg;

  localparam int PCT_SCALE = 100;
  localparam int OH_W      = 64;
  localparam int IDX_W     = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SCORE,
    S_DIV,
    S_DONE
  } score_state_t;

  function automatic logic is_onehot(input logic [OH_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [OH_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < OH_W; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, one quotient bit per cycle
module seq_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  q_r, r_r, d_r;
  logic          busy_r, done_r;
  logic [W:0]    shifted, diff;

  assign shifted = {r_r, q_r[W-1]};
  assign diff    = shifted - {1'b0, d_r};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      q_r    <= '0;
      r_r    <= '0;
      d_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (clr) begin
        cnt    <= '0;
        q_r    <= '0;
        r_r    <= '0;
        d_r    <= '0;
        busy_r <= 1'b0;
      end else if (start) begin
        q_r    <= dividend;
        r_r    <= '0;
        d_r    <= divisor;
        cnt    <= CW'(W);
        busy_r <= 1'b1;
      end else if (busy_r) begin
        // A borrow out of the trial subtraction means the divisor did not fit.
        if (!diff[W]) begin
          r_r <= diff[W-1:0];
          q_r <= {q_r[W-2:0], 1'b1};
        end else begin
          r_r <= shifted[W-1:0];
          q_r <= {q_r[W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = q_r;
  assign remainder = r_r;

endmodule

// File: rtl/inference_scoreboard.sv
// rtl/inference_scoreboard.sv - sequences an inference run and tracks accuracy statistics
module inference_scoreboard
  import nn_score_pkg::*;
#(
  parameter  int NUM_CLASSES = 10,
  parameter  int MAX_SAMPLES = 200,
  localparam int CNT_W       = $clog2(MAX_SAMPLES + 1),
  localparam int NUM_W       = $clog2(100 * MAX_SAMPLES + 1),
  localparam int SEL_W       = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst_overall,
  input  logic                   rst_vals,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_samples,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic [NUM_CLASSES-1:0] expected,
  input  logic [NUM_CLASSES-1:0] obtained,
  output logic                   next_req,
  output logic [6:0]             accuracy,
  output logic                   acc_valid,
  output logic                   done,
  output logic [CNT_W-1:0]       correct_count,
  output logic [CNT_W-1:0]       total_count,
  output logic [CNT_W-1:0]       invalid_count,
  output logic                   label_err,
  output logic [NUM_CLASSES-1:0] last_expected,
  output logic [NUM_CLASSES-1:0] last_obtained,
  input  logic [SEL_W-1:0]       class_sel,
  output logic [CNT_W-1:0]       class_correct,
  output logic [CNT_W-1:0]       class_total
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_SAMPLES);

  score_state_t state, state_nxt;

  logic [CNT_W-1:0]       n_r, correct_r, total_r, invalid_r;
  logic [CNT_W-1:0]       cls_corr_r [NUM_CLASSES];
  logic [CNT_W-1:0]       cls_tot_r  [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] exp_r, obt_r, last_exp_r, last_obt_r;
  logic [6:0]             acc_r;
  logic                   acc_valid_r, next_req_r, label_err_r;

  logic                   start_ok, exp_ok, obt_ok, hit;
  logic [CNT_W-1:0]       n_start, correct_nxt, total_nxt;
  logic [IDX_W-1:0]       cls_idx;
  logic [NUM_W-1:0]       div_quot, div_rem;
  logic                   div_busy, div_done;

  assign start_ok    = start && (state == S_IDLE || state == S_DONE);
  assign n_start     = (num_samples > MAX_N) ? MAX_N : num_samples;
  assign exp_ok      = is_onehot(OH_W'(exp_r));
  assign obt_ok      = is_onehot(OH_W'(obt_r));
  assign cls_idx     = onehot_to_idx(OH_W'(exp_r));
  assign hit         = exp_ok && obt_ok && (obt_r == exp_r);
  assign correct_nxt = correct_r + CNT_W'(hit);
  assign total_nxt   = total_r + 1'b1;

  // Divider is loaded during SCORE with the post-update counts so DIV spends exactly NUM_W cycles.
  seq_divider #(.W(NUM_W)) u_div (
    .clk       (clk),
    .rst       (rst_overall),
    .clr       (rst_vals),
    .start     (state == S_SCORE),
    .dividend  (NUM_W'(correct_nxt) * NUM_W'(PCT_SCALE)),
    .divisor   (NUM_W'(total_nxt)),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  logic unused_div;
  assign unused_div = ^{div_rem, div_quot[NUM_W-1:7], div_busy};

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rst_vals) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) state_nxt = (n_start == '0) ? S_DONE : S_WAIT;
        S_WAIT:         if (sample_valid) state_nxt = S_SCORE;
        S_SCORE:        state_nxt = S_DIV;
        S_DIV:          if (div_done) state_nxt = (total_r == n_r) ? S_DONE : S_WAIT;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      {n_r, correct_r, total_r, invalid_r} <= '0;
      {exp_r, obt_r, last_exp_r, last_obt_r} <= '0;
      {acc_r, acc_valid_r, next_req_r, label_err_r} <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        cls_corr_r[c] <= '0;
        cls_tot_r[c]  <= '0;
      end
    end else begin
      acc_valid_r <= 1'b0;
      next_req_r  <= 1'b0;
      if (rst_vals) begin
        {n_r, correct_r, total_r, invalid_r} <= '0;
        {exp_r, obt_r, last_exp_r, last_obt_r} <= '0;
        {acc_r, label_err_r} <= '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
          cls_corr_r[c] <= '0;
          cls_tot_r[c]  <= '0;
        end
      end else if (start_ok) begin
        n_r         <= n_start;
        next_req_r  <= (n_start != '0);
        {correct_r, total_r, invalid_r} <= '0;
        {acc_r, label_err_r} <= '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
          cls_corr_r[c] <= '0;
          cls_tot_r[c]  <= '0;
        end
      end else if (state == S_WAIT && sample_valid) begin
        exp_r <= expected;
        obt_r <= obtained;
      end else if (state == S_SCORE) begin
        total_r   <= total_nxt;
        correct_r <= correct_nxt;
        if (!exp_ok) label_err_r <= 1'b1;
        if (!obt_ok) invalid_r <= invalid_r + 1'b1;
        for (int c = 0; c < NUM_CLASSES; c++) begin
          if (exp_ok && cls_idx == IDX_W'(c)) begin
            cls_tot_r[c] <= cls_tot_r[c] + 1'b1;
            if (hit) cls_corr_r[c] <= cls_corr_r[c] + 1'b1;
          end
        end
      end else if (state == S_DIV && div_done) begin
        acc_r       <= div_quot[6:0];
        acc_valid_r <= 1'b1;
        last_exp_r  <= exp_r;
        last_obt_r  <= obt_r;
        next_req_r  <= (total_r != n_r);
      end
    end
  end

  assign sample_ready  = (state == S_WAIT);
  assign done          = (state == S_DONE);
  assign next_req      = next_req_r;
  assign accuracy      = acc_r;
  assign acc_valid     = acc_valid_r;
  assign correct_count = correct_r;
  assign total_count   = total_r;
  assign invalid_count = invalid_r;
  assign label_err     = label_err_r;
  assign last_expected = last_exp_r;
  assign last_obtained = last_obt_r;
  assign class_correct = (int'(class_sel) < NUM_CLASSES) ? cls_corr_r[class_sel] : '0;
  assign class_total   = (int'(class_sel) < NUM_CLASSES) ? cls_tot_r[class_sel]  : '0;

endmodule

// File: tb/tb_inference_scoreboard.sv
// tb/tb_inference_scoreboard.sv - directed self-checking bench for inference_scoreboard
module tb_inference_scoreboard;

  localparam int NC    = 10;
  localparam int CNT_W = 8;
  localparam int NUM_W = 15;
  localparam int LAT   = NUM_W + 2;

  logic          clk = 1'b0;
  logic          rst_overall = 1'b1;
  logic          rst_vals = 1'b0;
  logic          start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [NC-1:0] expected = '0;
  logic [NC-1:0] obtained = '0;
  logic          next_req;
  logic [6:0]    accuracy;
  logic          acc_valid;
  logic          done;
  logic [CNT_W-1:0] correct_count, total_count, invalid_count;
  logic          label_err;
  logic [NC-1:0] last_expected, last_obtained;
  logic [3:0]    class_sel = '0;
  logic [CNT_W-1:0] class_correct, class_total;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  inference_scoreboard #(.NUM_CLASSES(NC), .MAX_SAMPLES(200)) dut (
    .clk           (clk),
    .rst_overall   (rst_overall),
    .rst_vals      (rst_vals),
    .start         (start),
    .num_samples   (num_samples),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .expected      (expected),
    .obtained      (obtained),
    .next_req      (next_req),
    .accuracy      (accuracy),
    .acc_valid     (acc_valid),
    .done          (done),
    .correct_count (correct_count),
    .total_count   (total_count),
    .invalid_count (invalid_count),
    .label_err     (label_err),
    .last_expected (last_expected),
    .last_obtained (last_obtained),
    .class_sel     (class_sel),
    .class_correct (class_correct),
    .class_total   (class_total)
  );

  always #5 clk = ~clk;

  function automatic logic [NC-1:0] oh(input int i);
    logic [NC-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int n);
    num_samples = CNT_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_sample(input string tag, input logic [NC-1:0] e, input logic [NC-1:0] o,
                            input int exp_acc, input bit exp_next);
    int k;
    k = 0;
    while (!sample_ready && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_ready"}, sample_ready, 1);
    sample_valid = 1'b1;
    expected = e;
    obtained = o;
    tick();
    sample_valid = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!acc_valid && k < 40);
    chk({tag, "_lat"}, k, LAT);
    chk({tag, "_acc"}, accuracy, exp_acc);
    chk({tag, "_nreq"}, next_req, exp_next);
  endtask

  initial begin
    int pulses;
    int last_cyc;

    repeat (2) tick();
    chk("rst_ready", sample_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_acc", accuracy, 0);
    chk("rst_total", total_count, 0);
    chk("rst_nreq", next_req, 0);
    rst_overall = 1'b0;
    tick();

    // 1: three hits then a miss
    start_run(4);
    chk("t1_nreq0", next_req, 1);
    run_sample("t1s1", oh(3), oh(3), 100, 1);
    run_sample("t1s2", oh(5), oh(5), 100, 1);
    run_sample("t1s3", oh(0), oh(0), 100, 1);
    run_sample("t1s4", oh(2), oh(7), 75, 0);
    chk("t1_done", done, 1);
    chk("t1_correct", correct_count, 3);
    chk("t1_total", total_count, 4);
    chk("t1_last_exp", last_expected, oh(2));
    chk("t1_last_obt", last_obtained, oh(7));

    // 2: floor of 1/3, per-class counters
    start_run(3);
    chk("t2_cleared", total_count, 0);
    run_sample("t2s1", oh(1), oh(1), 100, 1);
    run_sample("t2s2", oh(1), oh(4), 50, 1);
    run_sample("t2s3", oh(9), oh(0), 33, 0);
    class_sel = 4'd1; #1;
    chk("t2_c1_tot", class_total, 2);
    chk("t2_c1_cor", class_correct, 1);
    class_sel = 4'd9; #1;
    chk("t2_c9_tot", class_total, 1);
    chk("t2_c9_cor", class_correct, 0);
    class_sel = 4'd4; #1;
    chk("t2_c4_tot", class_total, 0);
    class_sel = 4'd12; #1;
    chk("t2_oob_tot", class_total, 0);

    // 3: invalid network output, then malformed label
    start_run(2);
    run_sample("t3s1", oh(6), '0, 0, 1);
    chk("t3_invalid", invalid_count, 1);
    chk("t3_lerr0", label_err, 0);
    run_sample("t3s2", 10'b0000000011, oh(0), 0, 0);
    chk("t3_lerr1", label_err, 1);
    chk("t3_invalid2", invalid_count, 1);
    chk("t3_total", total_count, 2);
    chk("t3_correct", correct_count, 0);
    class_sel = 4'd6; #1;
    chk("t3_c6_tot", class_total, 1);
    class_sel = 4'd0; #1;
    chk("t3_c0_tot", class_total, 0);
    class_sel = 4'd1; #1;
    chk("t3_c1_tot", class_total, 0);

    // 4: empty run
    start_run(0);
    chk("t4_done", done, 1);
    chk("t4_acc", accuracy, 0);
    chk("t4_nreq", next_req, 0);
    chk("t4_ready", sample_ready, 0);
    chk("t4_total", total_count, 0);
    chk("t4_lerr", label_err, 0);
    tick();
    chk("t4_ready2", sample_ready, 0);
    chk("t4_nreq2", next_req, 0);

    // 5: sample_valid held high across the run
    start_run(3);
    sample_valid = 1'b1;
    expected = oh(2);
    obtained = oh(2);
    pulses = 0;
    last_cyc = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (acc_valid) begin
        if (pulses > 0) chk("t5_gap", cyc - last_cyc, NUM_W + 3);
        last_cyc = cyc;
        pulses++;
      end
    end
    sample_valid = 1'b0;
    chk("t5_pulses", pulses, 3);
    chk("t5_total", total_count, 3);
    chk("t5_correct", correct_count, 3);
    chk("t5_done", done, 1);

    // 6a: synchronous clear in the middle of a divide
    start_run(2);
    chk("t6_ready", sample_ready, 1);
    sample_valid = 1'b1;
    expected = oh(4);
    obtained = oh(4);
    tick();
    sample_valid = 1'b0;
    repeat (5) tick();
    chk("t6_total_pre", total_count, 1);
    rst_vals = 1'b1;
    tick();
    rst_vals = 1'b0;
    chk("t6_total", total_count, 0);
    chk("t6_correct", correct_count, 0);
    chk("t6_acc", accuracy, 0);
    chk("t6_ready_idle", sample_ready, 0);
    chk("t6_done", done, 0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (acc_valid) pulses++;
    end
    chk("t6_no_acc", pulses, 0);

    // 6b: asynchronous reset while waiting for a sample
    start_run(3);
    run_sample("t6s1", oh(8), oh(8), 100, 1);
    chk("t6_wait", sample_ready, 1);
    #2;
    rst_overall = 1'b1;
    #1;
    chk("t6_ar_ready", sample_ready, 0);
    chk("t6_ar_acc", accuracy, 0);
    chk("t6_ar_total", total_count, 0);
    chk("t6_ar_correct", correct_count, 0);
    chk("t6_ar_last", last_expected, 0);
    tick();
    rst_overall = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inference_scoreboard.md
Name: inference_scoreboard

Overview:
Parametrised successor to the inference accuracy tracker. Sequences a run of N inference samples, using a valid/ready handshake toward the network output and a next-sample request toward the input loader. Scores each one-hot prediction against its one-hot label and keeps global and per-class counters. Computes integer percent accuracy with a multi-cycle sequential divider instead of a combinational divide. Sits beside weight_layers/top_input_loader, replacing the inline accuracy logic in the top level.

Parameters:
NUM_CLASSES, 10, width of one-hot expected/obtained vectors
MAX_SAMPLES, 200, largest supported run length
CNT_W, $clog2(MAX_SAMPLES+1), counter width (derived, do not override)
NUM_W, $clog2(100*MAX_SAMPLES+1), dividend width and divider iteration count (derived)

Ports:
clk  in  1  clock
rst_overall  in  1  asynchronous, active-high reset
rst_vals  in  1  synchronous clear of run statistics, active-high
start  in  1  begin a run (honoured in IDLE or DONE only)
num_samples  in  CNT_W  run length, latched on start
sample_valid  in  1  expected/obtained valid
sample_ready  out  1  scoreboard can accept a sample
expected  in  NUM_CLASSES  one-hot label
obtained  in  NUM_CLASSES  one-hot network output
next_req  out  1  one-cycle pulse: loader fetches next sample
accuracy  out  7  floor(100*correct/total), 0..100
acc_valid  out  1  one-cycle pulse when accuracy updates
done  out  1  run complete, held
correct_count, total_count, invalid_count  out  CNT_W each  global counters
label_err  out  1  sticky: an expected vector was not one-hot
last_expected, last_obtained  out  NUM_CLASSES each  last scored pair
class_sel  in  $clog2(NUM_CLASSES)  per-class query index
class_correct, class_total  out  CNT_W each  combinational read of class_sel counters; 0 if class_sel >= NUM_CLASSES

Behaviour:
- rst_overall: all outputs and counters 0, state IDLE. rst_vals: same effect, synchronous, priority over every other input, aborts a run in any state including DIV.
- FSM states: IDLE, WAIT, SCORE, DIV, DONE.
- IDLE/DONE + start:
  - latch n = min(num_samples, MAX_SAMPLES); clear all counters, accuracy, label_err, done.
  - n==0: go to DONE, done=1 next cycle, no next_req.
  - otherwise: pulse next_req, go to WAIT.
- start in WAIT/SCORE/DIV is ignored.
- WAIT: sample_ready=1; sample_ready=0 in every other state. A sample is accepted on sample_valid&&sample_ready; register expected and obtained, go to SCORE.
- SCORE (1 cycle):
  - total_count+1.
  - expected not one-hot: set label_err, no per-class update, sample counts as incorrect.
  - obtained not one-hot (including all-zero): invalid_count+1, incorrect.
  - otherwise class_total[idx(expected)]+1; if obtained==expected, correct_count+1 and class_correct[idx]+1.
  - Go to DIV.
- DIV: restoring divide, dividend correct*100 (NUM_W bits), divisor total (never 0 here), exactly NUM_W cycles.
  - On completion: write accuracy, pulse acc_valid, update last_expected/last_obtained.
  - If total==n: go to DONE (done=1), else pulse next_req and go to WAIT.
- Latency: acc_valid asserts on the (NUM_W+2)th rising edge after the accepting edge. next_req for the following sample is on that same edge.
- done holds until start, rst_vals or rst_overall. Counters stay readable in DONE.
- Counters cannot overflow: total is bounded by n <= MAX_SAMPLES.

Decomposition:
- Package nn_score_pkg: state enum, helper functions is_onehot and onehot_to_idx, percent-scale constant 100.
- Sub-module seq_divider: start/busy/done handshake, parametrised width, quotient/remainder outputs. It is reused later for loss and statistics.

Test Plan:
(NUM_CLASSES=10, MAX_SAMPLES=200)
1. n=4; samples 3 correct then 1 wrong -> acc_valid values 100, 100, 100, 75; done=1; correct=3, total=4.
2. n=3; 1 correct, 2 wrong -> final accuracy 33 (floor); class_total of each used class as applied.
3. obtained=0 on a sample -> invalid_count=1, scored incorrect. expected=10'b0000000011 -> label_err=1, class counters unchanged.
4. n=0 + start -> done=1 next cycle, accuracy=0, no next_req, sample_ready stays 0.
5. Hold sample_valid=1 continuously -> exactly one accept per WAIT; acc_valid spacing equals NUM_W+3 cycles; no double count.
6. rst_vals asserted mid-DIV -> IDLE next edge, all counters/accuracy 0. rst_overall asserted asynchronously mid-WAIT -> outputs 0 immediately.
